hybrid_out_capture: RTL
=======================

// Module: hybrid_out_capture
// PURPOSE
//  - Downstream consumer of the hybrid-row test netlist's single-bit `out` stream.
//  - Deserializes qualified bits into WIDTH-bit words.
//  - Presents each word on a valid/ready port through a one-word holding register.
//  - Flags dropped words with a sticky overflow; serves as the sequential sink in hybrid-row floorplan/placement tests.
// PARAMETERS
//  WIDTH      8  bits per word; legal range 2..32
//  MSB_FIRST  1  1: first sampled bit lands in word_data[WIDTH-1]; 0: first bit lands in word_data[0]
// PORTS
//  clk          in   1      single clock; all state updates on posedge
//  rst          in   1      synchronous, active-high reset
//  in_bit       in   1      serial data, driven by upstream `out`
//  in_en        in   1      sample strobe; in_bit is shifted in only when 1
//  word_data    out  WIDTH  assembled word; stable while word_valid=1
//  word_valid   out  1      holding register is full
//  word_ready   in   1      consumer accepts word when word_valid&&word_ready
//  bit_cnt      out  5      bits collected toward the current word, 0..WIDTH-1
//  overflow     out  1      sticky: a completed word was dropped
//  ovf_clr      in   1      clears overflow
// BEHAVIOUR
//  - Reset (rst=1 at posedge), values next cycle:
//    - shreg=0, bit_cnt=0, word_data=0, word_valid=0, overflow=0, FSM=EMPTY.
//    - A partial word is discarded, and any held word is discarded.
//  - Shift: on in_en=1, shift in_bit into shreg per MSB_FIRST.
//    - bit_cnt increments, wrapping WIDTH-1 -> 0.
//    - in_en=0: shreg and bit_cnt hold.
//  - Completion: in_en=1 with bit_cnt==WIDTH-1.
//    - The completed word is {shreg shifted with in_bit}.
//    - Latency: word_valid=1 the cycle after the completing in_en.
//  - FSM EMPTY (word_valid=0):
//    - Completion -> load word_data, go to FULL.
//  - FSM FULL (word_valid=1):
//    - Handshake only, no completion -> go to EMPTY; word_valid=0 next cycle.
//    - Handshake and completion in the same cycle -> load the new word, stay FULL. No bubble and no drop.
//    - Completion without handshake -> drop the new word, keep the old word_data, overflow<=1.
//  - word_data changes only on a load or on reset; the consumer never sees a torn word.
//  - ovf_clr=1 clears overflow next cycle.
//    - If a drop occurs in the same cycle, set wins and overflow stays 1.
//  - word_ready while EMPTY is ignored.
//  - Throughput: one word every WIDTH in_en cycles with word_ready tied high.
// CONFIGURATION
//  - HYBRID_CAPTURE_PARITY_EN defined:
//    - Adds output `word_parity` (1 bit) = XOR of the loaded word.
//    - Registered with word_data, same latency; reset value 0.
//    - Adds output `par_err` (1 bit): 1-cycle pulse when a loaded word has odd parity while input `par_odd_exp`=0, or even parity while `par_odd_exp`=1.
//  - Undefined: no parity ports and no parity logic; all other behaviour identical.
// TESTING
//  - T1 reset: rst for 2 cycles mid-word (bit_cnt=3) -> all outputs 0 next cycle; 8 more bits yield one word with no residue.
//  - T2 MSB_FIRST=1, WIDTH=8, word_ready=1: bits 1,0,1,0,0,1,1,0 on consecutive in_en
//    -> word_data=8'hA6 and word_valid=1 exactly 1 cycle after the 8th bit.
//  - T3 gaps: same bits with in_en toggling 1,0 -> same 8'hA6; bit_cnt holds during in_en=0.
//  - T4 backpressure: word_ready=0 while 2 words stream in
//    -> first word held; second dropped; overflow=1; ovf_clr=1 -> overflow=0 next cycle.
//  - T5 simultaneous handshake: word 8'h5A held FULL, 8'hC3 completes on the same cycle as word_ready=1
//    -> next cycle word_data=8'hC3, word_valid=1, overflow=0.
//  - T6 (HYBRID_CAPTURE_PARITY_EN): word 8'h07 with par_odd_exp=0 -> word_parity=1 and a par_err pulse;
//    word 8'h03 -> word_parity=0, no pulse.

Source files
------------

// File: rtl/hybrid_out_capture.sv
// Serial-to-word capture sink: deserializes qualified bits into WIDTH-bit
// words behind a one-word valid/ready holding register with sticky overflow.
// Ports: clk, rst (sync, active-high), in_bit/in_en (serial in),
//   word_data/word_valid/word_ready (word out), bit_cnt, overflow/ovf_clr.
// Optional HYBRID_CAPTURE_PARITY_EN adds par_odd_exp, word_parity, par_err.
module hybrid_out_capture #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_en,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [4:0]       bit_cnt,
  output logic             overflow,
`ifdef HYBRID_CAPTURE_PARITY_EN
  input  logic             par_odd_exp,
  output logic             word_parity,
  output logic             par_err,
`endif
  input  logic             ovf_clr
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             complete;
  logic             load;
  logic             drop;

  // Shift direction decides which end the first bit ends up at.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (in_en) begin
      if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], in_bit};
      else           shreg_d = {in_bit, shreg_q[WIDTH-1:1]};
      cnt_d = complete ? 5'd0 : cnt_q + 5'd1;
    end
  end

  assign complete = in_en && (cnt_q == 5'(WIDTH-1));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (complete) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (complete) begin
          // A same-cycle handshake frees the slot for the new word.
          if (word_ready) load = 1'b1;
          else            drop = 1'b1;
        end else if (word_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign data_d = load ? shreg_d : data_q;
  // Set has priority over clear.
  assign ovf_d  = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      shreg_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign word_data  = data_q;
  assign word_valid = (state_q == FULL);
  assign bit_cnt    = cnt_q;
  assign overflow   = ovf_q;

`ifdef HYBRID_CAPTURE_PARITY_EN
  logic par_q, perr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (load) par_q <= ^shreg_d;
      perr_q <= load && ((^shreg_d) != par_odd_exp);
    end
  end

  assign word_parity = par_q;
  assign par_err     = perr_q;
`endif

endmodule
